// File: rtl/instr_fetch_decode.sv
// Purpose : fetch ARM instruction words from imem, decode into opcode/operand fields and issue them.
// Latency : start -> imem_req 1 cycle; ack in FETCH -> issue_valid 2 cycles later.
// Backpressure: issue fields are held while issue_ready=0; fetch waits with no timeout for imem_ack.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   start                    one-cycle pulse, leaves IDLE
//   imem_req/addr/ack/data   single-outstanding instruction read (addr = pc)
//   issue_valid/ready        valid/ready handshake toward the execute core
//   opcode, oprand1..3       decoded fields, forced to zero whenever issue_valid=0
//   halted, illegal          HALT reached; illegal marks an unrecognised opcode class
//   retired                  count of issued instructions (wraps modulo 2^32)
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] opcode,
    output logic [31:0] oprand1,
    output logic [31:0] oprand2,
    output logic [31:0] oprand3,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        r_imem_req;
    logic        r_issue_valid;
    logic        r_halted;
    logic        r_illegal;
    logic [31:0] r_opcode;
    logic [31:0] r_oprand1;
    logic [31:0] r_oprand2;
    logic [31:0] r_oprand3;

    logic [11:0] w_class;
    logic        w_dp;
    logic        w_ls;
    logic        w_svc;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_op3;

    // Decode of the captured word; only consumed in DECODE (fields) and ISSUE (svc check).
    always_comb begin
        w_class = r_instr[31:20];
        w_dp    = 1'b0;
        w_ls    = 1'b0;
        w_svc   = 1'b0;
        w_op1   = 32'd0;
        w_op2   = 32'd0;
        w_op3   = 32'd0;
        case (w_class)
            12'hE1A, 12'hE3A, 12'hE04, 12'hE24, 12'hE08,
            12'hE28, 12'hE00, 12'hE20, 12'hE18, 12'hE38: w_dp  = 1'b1;
            12'hE59, 12'hE58, 12'hE78, 12'hE52, 12'hE49: w_ls  = 1'b1;
            12'hEF0:                                      w_svc = 1'b1;
            default: ;
        endcase
        if (w_dp) begin
            w_op1 = {28'd0, r_instr[15:12]};
            // bit 25 selects the 8-bit immediate form; no rotation is applied
            w_op2 = r_instr[25] ? {24'd0, r_instr[7:0]} : {28'd0, r_instr[3:0]};
        end else if (w_ls) begin
            w_op1 = {28'd0, r_instr[15:12]};
            w_op2 = {28'd0, r_instr[19:16]};
            // bit 25 set means register offset, otherwise the 12-bit immediate
            w_op3 = r_instr[25] ? {28'd0, r_instr[3:0]} : {20'd0, r_instr[11:0]};
        end else if (w_svc) begin
            w_op1 = {8'd0, r_instr[23:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_retired     <= 32'd0;
            r_imem_req    <= 1'b0;
            r_issue_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal     <= 1'b0;
            r_opcode      <= 32'd0;
            r_oprand1     <= 32'd0;
            r_oprand2     <= 32'd0;
            r_oprand3     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // request is a single-cycle pulse regardless of ack
                    r_imem_req <= 1'b0;
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_state <= S_DECODE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_dp || w_ls || w_svc) begin
                        r_state       <= S_ISSUE;
                        r_issue_valid <= 1'b1;
                        r_opcode      <= {20'd0, w_class};
                        r_oprand1     <= w_op1;
                        r_oprand2     <= w_op2;
                        r_oprand3     <= w_op3;
                    end else begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        // fields return to the all-zero no-op as soon as valid drops
                        r_issue_valid <= 1'b0;
                        r_opcode      <= 32'd0;
                        r_oprand1     <= 32'd0;
                        r_oprand2     <= 32'd0;
                        r_oprand3     <= 32'd0;
                        r_retired     <= r_retired + 32'd1;
                        r_pc          <= r_pc + 32'd4;
                        if (w_svc) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign issue_valid = r_issue_valid;
    assign opcode      = r_opcode;
    assign oprand1     = r_oprand1;
    assign oprand2     = r_oprand2;
    assign oprand3     = r_oprand3;
    assign halted      = r_halted;
    assign illegal     = r_illegal;
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: one default-reset-PC instance plus one with the top-of-memory
// reset PC, both driven by the same stimulus. Issued instructions of the default instance are
// matched against a scoreboard queue filled when the instruction word is presented.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst, start, imem_ack, issue_ready;
    logic [31:0] imem_data;

    logic        req0, vld0, hlt0, ill0;
    logic [31:0] addr0, opc0, op10, op20, op30, ret0;
    logic        req1, vld1, hlt1, ill1;
    logic [31:0] addr1, opc1, op11, op21, op31, ret1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] opc;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] o3;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_decode u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack), .imem_data(imem_data),
        .issue_valid(vld0), .issue_ready(issue_ready),
        .opcode(opc0), .oprand1(op10), .oprand2(op20), .oprand3(op30),
        .halted(hlt0), .illegal(ill0), .retired(ret0)
    );

    instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_data(imem_data),
        .issue_valid(vld1), .issue_ready(issue_ready),
        .opcode(opc1), .oprand1(op11), .oprand2(op21), .oprand3(op31),
        .halted(hlt1), .illegal(ill1), .retired(ret1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        exp_t e;
        e.opc = o; e.o1 = a; e.o2 = b; e.o3 = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; issue_ready = 1'b0; imem_data = 32'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // A handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && vld0 && issue_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_opcode", opc0, e.opc);
                chk("sb_oprand1", op10, e.o1);
                chk("sb_oprand2", op20, e.o2);
                chk("sb_oprand3", op30, e.o3);
            end
        end
    end

    initial begin
        // ---- reset state
        do_reset();
        chk("rst_req", {31'd0, req0}, 32'd0);
        chk("rst_valid", {31'd0, vld0}, 32'd0);
        chk("rst_halted", {31'd0, hlt0}, 32'd0);
        chk("rst_illegal", {31'd0, ill0}, 32'd0);
        chk("rst_addr0", addr0, 32'd0);
        chk("rst_addr1", addr1, 32'hFFFF_FFFC);
        chk("rst_retired", ret0, 32'd0);
        chk("rst_opcode", opc0, 32'd0);

        // ---- mov immediate, ack in the FETCH cycle, ready high
        start = 1'b1; imem_data = 32'hE3A0_1005; issue_ready = 1'b1;
        push(32'hE3A, 32'd1, 32'd5, 32'd0);
        tick();
        chk("t1_req_fetch", {31'd0, req0}, 32'd1);
        chk("t1_addr_fetch", addr0, 32'd0);
        start = 1'b0; imem_ack = 1'b1;
        tick();
        chk("t1_req_decode", {31'd0, req0}, 32'd0);
        chk("t1_valid_decode", {31'd0, vld0}, 32'd0);
        imem_ack = 1'b0;
        tick();
        chk("t1_valid_3cyc", {31'd0, vld0}, 32'd1);
        tick();
        chk("t1_retired", ret0, 32'd1);
        chk("t1_pc", addr0, 32'd4);
        chk("t1_valid_low", {31'd0, vld0}, 32'd0);
        chk("t1_opcode_zero", opc0, 32'd0);
        chk("t1_refetch_req", {31'd0, req0}, 32'd1);

        // ---- reset in WAIT with an ack in the same cycle
        issue_ready = 1'b0;
        tick();
        chk("t6_wait_req", {31'd0, req0}, 32'd0);
        chk("t6_wait_addr", addr0, 32'd4);
        rst = 1'b1; imem_ack = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_addr0", addr0, 32'd0);
        chk("t6_addr1", addr1, 32'hFFFF_FFFC);
        chk("t6_retired", ret0, 32'd0);
        chk("t6_valid", {31'd0, vld0}, 32'd0);
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_valid", {31'd0, vld0}, 32'd0);
            chk("t6_idle_req", {31'd0, req0}, 32'd0);
        end
        imem_ack = 1'b0;

        // ---- unrecognised class after a 4-cycle fetch latency
        do_reset();
        start = 1'b1; imem_data = 32'hE790_2003; issue_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_req", {31'd0, req0}, 32'd0);
            chk("t2_wait_addr", addr0, 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("t2_decode_valid", {31'd0, vld0}, 32'd0);
        tick();
        chk("t2_halted", {31'd0, hlt0}, 32'd1);
        chk("t2_illegal", {31'd0, ill0}, 32'd1);
        chk("t2_valid", {31'd0, vld0}, 32'd0);
        issue_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t2_halt_req", {31'd0, req0}, 32'd0);
        chk("t2_halt_retired", ret0, 32'd0);
        chk("t2_halt_valid", {31'd0, vld0}, 32'd0);

        // ---- store with 5 cycles of backpressure
        do_reset();
        start = 1'b1; imem_data = 32'hE780_2003; issue_ready = 1'b0;
        push(32'hE78, 32'd2, 32'd0, 32'd3);
        tick();
        start = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) issue_ready = 1'b1;
            chk("t3_valid_held", {31'd0, vld0}, 32'd1);
            chk("t3_opcode_held", opc0, 32'hE78);
            chk("t3_op1_held", op10, 32'd2);
            chk("t3_op2_held", op20, 32'd0);
            chk("t3_op3_held", op30, 32'd3);
            chk("t3_retired_held", ret0, 32'd0);
            tick();
        end
        chk("t3_retired", ret0, 32'd1);
        chk("t3_valid_low", {31'd0, vld0}, 32'd0);
        tick();
        tick();
        chk("t3_retired_once", ret0, 32'd1);

        // ---- pc wrap on the top-of-memory instance
        do_reset();
        start = 1'b1; imem_data = 32'hE288_8001; issue_ready = 1'b1;
        push(32'hE28, 32'd8, 32'd1, 32'd0);
        tick();
        chk("t4_addr_top", addr1, 32'hFFFF_FFFC);
        start = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("t4_valid1", {31'd0, vld1}, 32'd1);
        chk("t4_opcode1", opc1, 32'hE28);
        chk("t4_op1_1", op11, 32'd8);
        chk("t4_op2_1", op21, 32'd1);
        chk("t4_op3_1", op31, 32'd0);
        tick();
        chk("t4_addr_wrap", addr1, 32'd0);
        chk("t4_retired1", ret1, 32'd1);
        chk("t4_addr0", addr0, 32'd4);

        // ---- svc issues and then halts legally
        do_reset();
        start = 1'b1; imem_data = 32'hEF00_0011; issue_ready = 1'b1;
        push(32'hEF0, 32'h11, 32'd0, 32'd0);
        tick();
        start = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("t5_valid", {31'd0, vld0}, 32'd1);
        tick();
        chk("t5_halted", {31'd0, hlt0}, 32'd1);
        chk("t5_illegal", {31'd0, ill0}, 32'd0);
        chk("t5_retired", ret0, 32'd1);
        chk("t5_valid_low", {31'd0, vld0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; imem_ack = 1'b1;
            tick();
            start = 1'b0; imem_ack = 1'b0;
            chk("t5_start_ignored", {31'd0, req0}, 32'd0);
            tick();
            chk("t5_still_halted", {31'd0, hlt0}, 32'd1);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
